instr_mem_loader: RTL

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/instr_mem_loader.sv
// Packs a big-endian byte stream into 32-bit words and writes them to instruction memory from base_addr.
// One word per 5 cycles: 4 byte accepts, then 1 write. in_ready stalls while writing. LOADER_CHECKSUM_EN adds a trailing checksum byte.
module instr_mem_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              error
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   word_idx;
  logic [1:0]        byte_cnt;
  logic [23:0]       asm_buf;
  logic              last_word;

  assign last_word = ((word_idx + (ADDR_W+1)'(1)) == cnt);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (word_count == '0) ? DONE : RECV;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_nxt = (word_count == '0) ? DONE : RECV;
      end
      RECV: begin
        in_ready = 1'b1;
        if (in_valid && byte_cnt == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        if (!last_word) state_nxt = RECV;
`ifdef LOADER_CHECKSUM_EN
        else state_nxt = CHK;
`else
        else state_nxt = DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = DONE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum  <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          csum  <= '0;
          err_q <= 1'b0;
        end
        RECV: if (in_valid) csum <= csum + in_data;
        CHK:  if (in_valid) err_q <= ((csum + in_data) != 8'd0);
        default: ;
      endcase
    end
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  // mem_a/mem_d load on the 4th byte so they are stable in WRITE and hold afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      base     <= '0;
      cnt      <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      asm_buf  <= '0;
      mem_a    <= '0;
      mem_d    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, DONE: if (start) begin
          base     <= base_addr;
          cnt      <= word_count;
          word_idx <= '0;
          byte_cnt <= '0;
        end
        RECV: if (in_valid) begin
          byte_cnt <= byte_cnt + 2'd1;
          asm_buf  <= {asm_buf[15:0], in_data};
          if (byte_cnt == 2'd3) begin
            mem_a <= base + word_idx[ADDR_W-1:0];
            mem_d <= {asm_buf, in_data};
          end
        end
        WRITE: word_idx <= word_idx + (ADDR_W+1)'(1);
        default: ;
      endcase
    end
  end

endmodule
